// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one 32-bit word per line,
// filled byte-serially from a memory arbiter.
// Build option: define ICACHE_EN to keep filled lines across requests. Without
// it the line store shrinks to a two-entry holding buffer that is emptied after
// every response, flush and reset, so every request refills each word it needs.
module icache #(
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] next_PC,
  input  logic        next_inst,
  input  logic        flush,
  output logic        inst_rdy,
  output logic [31:0] inst_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_data
);

`ifdef ICACHE_EN
  localparam bit KEEP_LINES = 1'b1;
`else
  localparam bit KEEP_LINES = 1'b0;
`endif
  // Two entries (indexed by word-address bit 0) are enough to hold both words
  // of a straddling fetch when lines are not retained.
  localparam int unsigned LINE_BITS = KEEP_LINES ? INDEX_BITS : 1;
  localparam int unsigned NLINES    = 1 << LINE_BITS;
  localparam int unsigned TAG_W     = 30 - LINE_BITS;

  typedef enum logic [1:0] {IDLE, RESP, FILL} state_t;

  state_t                state;
  logic [NLINES-1:0]     valid;
  logic [TAG_W-1:0]      tag_mem  [NLINES];
  logic [31:0]           data_mem [NLINES];
  logic [23:0]           fill_buf;
  logic [1:0]            byte_cnt;

  logic [29:0]           w0_c;
  logic [29:0]           w1_c;
  logic [LINE_BITS-1:0]  l0_c;
  logic [LINE_BITS-1:0]  l1_c;
  logic                  hit0_c;
  logic                  hit1_c;
  logic [31:0]           d0_c;
  logic [15:0]           d1_lo_c;
  logic                  look_hit_c;
  logic [31:0]           look_inst_c;
  logic [29:0]           miss_w_c;
  logic [LINE_BITS-1:0]  fill_line_c;
  logic                  fill_wr_c;
  logic                  unused_ok_c;

  // Bit 0 of the fetch address is architecturally ignored.
  assign unused_ok_c = next_PC[0];

  // Tag lookup for the addressed word and its successor (wraps modulo 2^30).
  assign w0_c    = next_PC[31:2];
  assign w1_c    = w0_c + 30'd1;
  assign l0_c    = w0_c[LINE_BITS-1:0];
  assign l1_c    = w1_c[LINE_BITS-1:0];
  assign hit0_c  = valid[l0_c] && (tag_mem[l0_c] == w0_c[29:LINE_BITS]);
  assign hit1_c  = valid[l1_c] && (tag_mem[l1_c] == w1_c[29:LINE_BITS]);
  assign d0_c    = data_mem[l0_c];
  assign d1_lo_c = data_mem[l1_c][15:0];

  // Decide hit/miss and assemble the instruction; on a miss pick the
  // lowest-addressed missing word.
  always_comb begin
    look_hit_c  = 1'b0;
    look_inst_c = 32'h0;
    miss_w_c    = w0_c;
    if (!next_PC[1]) begin
      look_hit_c  = hit0_c;
      look_inst_c = d0_c;
    end else if (!hit0_c) begin
      miss_w_c    = w0_c;
    end else if (d0_c[17:16] != 2'b11) begin
      look_hit_c  = 1'b1;
      look_inst_c = {16'h0, d0_c[31:16]};
    end else begin
      look_hit_c  = hit1_c;
      look_inst_c = {d1_lo_c, d0_c[31:16]};
      miss_w_c    = w1_c;
    end
  end

  // Last byte of a fill accepted this cycle: commit the line.
  assign fill_line_c = mem_addr[LINE_BITS+1:2];
  assign fill_wr_c   = rst_in && rdy_in && !flush && (state == FILL) &&
                       mem_rdy && (byte_cnt == 2'd3);

  // Line tag/data store; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (fill_wr_c) begin
      tag_mem[fill_line_c]  <= mem_addr[31:LINE_BITS+2];
      data_mem[fill_line_c] <= {mem_data, fill_buf};
    end
  end

  // Control FSM: lookup, response pulse, byte-serial fill; flush and rdy_in gate everything.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state    <= IDLE;
      valid    <= '0;
      inst_rdy <= 1'b0;
      inst_in  <= 32'h0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      byte_cnt <= 2'd0;
      fill_buf <= 24'h0;
    end else if (rdy_in) begin
      if (flush) begin
        state    <= IDLE;
        inst_rdy <= 1'b0;
        mem_req  <= 1'b0;
        byte_cnt <= 2'd0;
        if (!KEEP_LINES) begin
          valid <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (next_inst) begin
              if (look_hit_c) begin
                inst_rdy <= 1'b1;
                inst_in  <= look_inst_c;
                state    <= RESP;
                if (!KEEP_LINES) begin
                  valid <= '0;
                end
              end else begin
                mem_req  <= 1'b1;
                mem_addr <= {miss_w_c, 2'b00};
                byte_cnt <= 2'd0;
                state    <= FILL;
              end
            end
          end
          RESP: begin
            inst_rdy <= 1'b0;
            state    <= IDLE;
          end
          FILL: begin
            if (mem_rdy) begin
              mem_addr <= mem_addr + 32'd1;
              byte_cnt <= byte_cnt + 2'd1;
              case (mem_addr[1:0])
                2'd0:    fill_buf[7:0]   <= mem_data;
                2'd1:    fill_buf[15:8]  <= mem_data;
                2'd2:    fill_buf[23:16] <= mem_data;
                default: fill_buf        <= fill_buf;
              endcase
              if (byte_cnt == 2'd3) begin
                valid[fill_line_c] <= 1'b1;
                mem_req            <= 1'b0;
                state              <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus randomized fetch traffic, checked every
// cycle against a word-level model of the cache contents and memory.
module tb_icache;
  localparam int unsigned INDEX_BITS = 5;
  localparam int unsigned NL = 1 << INDEX_BITS;
`ifdef ICACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif

  logic        clk, rst_in, rdy_in, next_inst, flush, mem_rdy;
  logic [31:0] next_PC;
  logic [7:0]  mem_data;
  logic        inst_rdy, mem_req;
  logic [31:0] inst_in, mem_addr;

  icache #(.INDEX_BITS(INDEX_BITS)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .next_PC(next_PC),
    .next_inst(next_inst), .flush(flush), .inst_rdy(inst_rdy),
    .inst_in(inst_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdy(mem_rdy), .mem_data(mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int fills_seen = 0;

  logic [31:0] memw [logic [29:0]];

  // Backing memory: explicit words where set, otherwise a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    logic [31:0] h;
    if (memw.exists(w)) return memw[w];
    h = {2'b00, w} * 32'h9E37_79B1 + 32'h7F4A_7C15;
    return h ^ (h >> 15);
  endfunction

  // Instruction the fetch stage must receive for a PC, straight from memory.
  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] a, b;
    a = mem_word(pc[31:2]);
    b = mem_word(pc[31:2] + 30'd1);
    if (!pc[1]) return a;
    if (a[17:16] != 2'b11) return {16'h0, a[31:16]};
    return {b[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of what the cache currently holds, keyed by full word address.
  logic [29:0] mc_w [NL];
  bit          mc_v [NL];
  logic [29:0] held [$];

  function automatic int line_of(input logic [29:0] w);
    return int'(w[INDEX_BITS-1:0]);
  endfunction

  function automatic bit m_has(input logic [29:0] w);
    if (CACHED) return mc_v[line_of(w)] && (mc_w[line_of(w)] == w);
    foreach (held[i]) if (held[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_insert(input logic [29:0] w);
    if (CACHED) begin
      mc_v[line_of(w)] = 1'b1;
      mc_w[line_of(w)] = w;
    end else begin
      held.push_back(w);
    end
  endfunction

  function automatic void m_drop();
    if (!CACHED) held.delete();
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < int'(NL); i++) mc_v[i] = 1'b0;
    held.delete();
  endfunction

  // Per-edge reference: derive the outputs each edge must produce, then compare.
  bit          armed = 1'b0;
  logic        e_rdy, e_req;
  logic [31:0] e_inst, e_addr;
  logic        last_rdy = 1'b0;
  logic        last_req = 1'b0;

  initial begin
    logic [29:0] w, w1, mw;
    bit          miss;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_in) begin
        e_rdy = 1'b0; e_req = 1'b0; e_inst = 32'h0; e_addr = 32'h0;
        m_reset();
        armed = 1'b1;
      end else if (armed && rdy_in) begin
        if (flush) begin
          e_rdy = 1'b0; e_req = 1'b0;
          m_drop();
        end else if (e_req) begin
          if (mem_rdy) begin
            if (e_addr[1:0] == 2'b11) begin
              m_insert(e_addr[31:2]);
              e_req = 1'b0;
            end else begin
              e_addr = e_addr + 32'd1;
            end
          end
        end else if (e_rdy) begin
          e_rdy = 1'b0;
        end else if (next_inst) begin
          w = next_PC[31:2];
          w1 = w + 30'd1;
          a = mem_word(w);
          miss = 1'b0;
          mw = w;
          if (!m_has(w)) begin
            miss = 1'b1; mw = w;
          end else if (next_PC[1] && a[17:16] == 2'b11 && !m_has(w1)) begin
            miss = 1'b1; mw = w1;
          end
          if (miss) begin
            e_req = 1'b1;
            e_addr = {mw, 2'b00};
          end else begin
            e_rdy = 1'b1;
            e_inst = exp_inst(next_PC);
            m_drop();
          end
        end
      end
      if (armed) begin
        check("inst_rdy", 32'(inst_rdy), 32'(e_rdy));
        check("inst_in", inst_in, e_inst);
        check("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req || !rst_in) check("mem_addr", mem_addr, e_addr);
        if (rdy_in) check("rdy_twice", 32'(inst_rdy && last_rdy), 32'd0);
        if (mem_req && !last_req) fills_seen++;
        last_rdy = inst_rdy;
        last_req = mem_req;
      end
    end
  end

  // Memory arbiter: random byte-ready (also while idle), data from the current address.
  initial begin
    logic [31:0] d;
    mem_rdy = 1'b0;
    mem_data = 8'h0;
    forever begin
      @(negedge clk);
      mem_rdy = ($urandom_range(0, 3) != 0);
      if (mem_req) begin
        d = mem_word(mem_addr[31:2]);
        mem_data = 8'(d >> {mem_addr[1:0], 3'b000});
      end else begin
        mem_data = 8'($urandom);
      end
    end
  end

  // Present a fetch and wait for its pulse (or a random flush that aborts it).
  task automatic fetch(input logic [31:0] pc, input bit stall, input bit may_flush,
                       output int lat);
    bit ok;
    next_PC = pc;
    next_inst = 1'b1;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (flush) begin
        flush = 1'b0;
        ok = 1'b1;
        break;
      end
      if (inst_rdy) begin
        ok = 1'b1;
        break;
      end
      rdy_in = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
      if (may_flush && $urandom_range(0, 59) == 0) begin
        rdy_in = 1'b1;
        flush = 1'b1;
        next_inst = 1'b0;
      end
    end
    rdy_in = 1'b1;
    next_inst = 1'b0;
    flush = 1'b0;
    check("fetch_done", 32'(ok), 32'd1);
  endtask

  task automatic wait_fill_byte(input logic [1:0] off);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr[1:0] == off) begin
        ok = 1'b1;
        break;
      end
    end
    check("fill_progress", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    next_inst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  initial begin
    int          lat, f0;
    logic [31:0] a, pc;
    logic [29:0] w;
    int          r;
    rst_in = 1'b0; rdy_in = 1'b1; next_inst = 1'b0; flush = 1'b0; next_PC = 32'h0;
    memw[30'd0] = 32'h0000_0013;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;

    // Cold fetch then refetch of word 0.
    f0 = fills_seen;
    fetch(32'h0, 1'b0, 1'b0, lat);
    check("cold_inst", inst_in, 32'h0000_0013);
    check("cold_fills", 32'(fills_seen - f0), 32'd1);
    @(negedge clk);
    f0 = fills_seen;
    fetch(32'h0, 1'b0, 1'b0, lat);
    check("refetch_inst", inst_in, 32'h0000_0013);
    check("refetch_fast", 32'(lat == 1), 32'(CACHED));
    check("refetch_fills", 32'(fills_seen - f0), CACHED ? 32'd0 : 32'd1);

    // Compressed upper half needs one word only.
    do_reset();
    memw[30'd0] = 32'h4505_0001;
    memw[30'd1] = 32'h0093_1234;
    memw[30'd2] = 32'hBEEF_0000;
    check("model_pin_c", exp_inst(32'h2), 32'h0000_4505);
    check("model_pin_s", exp_inst(32'h6), 32'h0000_0093);
    f0 = fills_seen;
    fetch(32'h2, 1'b0, 1'b0, lat);
    check("compr_inst", inst_in, 32'h0000_4505);
    check("compr_fills", 32'(fills_seen - f0), 32'd1);

    // Straddling 32-bit instruction fills two words in address order.
    @(negedge clk);
    f0 = fills_seen;
    fetch(32'h6, 1'b0, 1'b0, lat);
    check("strad_inst", inst_in, 32'h0000_0093);
    check("strad_fills", 32'(fills_seen - f0), 32'd2);

    // Flush after two bytes of a fill discards it.
    @(negedge clk);
    next_PC = 32'h100;
    next_inst = 1'b1;
    wait_fill_byte(2'd2);
    flush = 1'b1;
    next_inst = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_req", 32'(mem_req), 32'd0);
    check("flush_rdy", 32'(inst_rdy), 32'd0);
    f0 = fills_seen;
    fetch(32'h100, 1'b0, 1'b0, lat);
    check("flush_refill", 32'(fills_seen - f0), 32'd1);

    // Conflict on line 0: 0x80 evicts 0x0.
    @(negedge clk);
    fetch(32'h0, 1'b0, 1'b0, lat);
    @(negedge clk);
    f0 = fills_seen;
    fetch(32'h80, 1'b0, 1'b0, lat);
    check("conflict_fills", 32'(fills_seen - f0), 32'd1);
    @(negedge clk);
    f0 = fills_seen;
    fetch(32'h0, 1'b0, 1'b0, lat);
    check("evict_refill", 32'(fills_seen - f0), 32'd1);
    check("evict_inst", inst_in, 32'h4505_0001);

    // rdy_in low for three cycles mid-fill freezes the address.
    @(negedge clk);
    next_PC = 32'h200;
    next_inst = 1'b1;
    wait_fill_byte(2'd1);
    a = mem_addr;
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_addr", mem_addr, a);
    end
    rdy_in = 1'b1;
    fetch(32'h200, 1'b0, 1'b0, lat);
    check("stall_inst", inst_in, exp_inst(32'h200));

    // Reset in the middle of a fill.
    @(negedge clk);
    next_PC = 32'h300;
    next_inst = 1'b1;
    wait_fill_byte(2'd2);
    do_reset();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_inst", inst_in, 32'h0);

    // Randomized traffic with stalls, flushes, idle gaps and address wrap.
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 15);
      if (r == 0) w = 30'h3FFF_FFFF;
      else w = 30'($urandom_range(0, 127));
      pc = {w, (r == 0) ? 1'b1 : 1'($urandom), 1'($urandom)};
      fetch(pc, 1'b1, 1'b1, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
